// File: rtl/tinyarch_pkg.sv
// Shared tinyarch types: operand-select modes, sequencer states and the
// default frame-base register.
package tinyarch_pkg;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'b00,
    MODE_FRAME  = 2'b01,
    MODE_BURST  = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

  localparam logic [3:0] FRAME_BASE_REG = 4'hd;

endpackage

// File: rtl/reg_index_gen.sv
// Combinational register-index helper: the first index for a new request and
// the wrapped successor of the current field.
module reg_index_gen
  import tinyarch_pkg::*;
#(
  parameter int                 FIELD_W    = 3,
  parameter int                 REG_AW     = 4,
  parameter logic [REG_AW-1:0]  FRAME_BASE = REG_AW'(FRAME_BASE_REG)
) (
  input  mode_t               mode,
  input  logic [FIELD_W-1:0]  field,
  input  logic [FIELD_W-1:0]  cur_field,
  output logic [REG_AW-1:0]   start_idx,
  output logic [REG_AW-1:0]   next_idx
);

  logic [FIELD_W-1:0] inc_field;

  // Field wraps modulo 2^FIELD_W; the upper address bits are always zero.
  assign inc_field = cur_field + FIELD_W'(1);
  assign next_idx  = {{(REG_AW-FIELD_W){1'b0}}, inc_field};

  always_comb begin
    start_idx = {{(REG_AW-FIELD_W){1'b0}}, field};
    if (mode == MODE_FRAME) start_idx = FRAME_BASE;
  end

endmodule

// File: rtl/reg_operand_sequencer.sv
// Second-operand register sequencer: issues the encoded register, the frame
// base, or a burst of consecutive registers toward the register-file port.
module reg_operand_sequencer
  import tinyarch_pkg::*;
#(
  parameter int                 INSTR_W    = 9,
  parameter int                 FIELD_W    = 3,
  parameter int                 REG_AW     = 4,
  parameter logic [REG_AW-1:0]  FRAME_BASE = REG_AW'(FRAME_BASE_REG),
  parameter int                 MAX_BURST  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [INSTR_W-1:0]            instr,
  input  mode_t                         mode,
  input  logic [$clog2(MAX_BURST)-1:0]  burst_len,
  input  logic                          stall,
  output logic [REG_AW-1:0]             reg2,
  output logic                          reg2_valid,
  output logic [$clog2(MAX_BURST)-1:0]  offset,
  output logic                          busy,
  output logic                          done
);

  localparam int CNT_W = $clog2(MAX_BURST);

  state_t             state;
  logic [CNT_W:0]     remaining;
  logic [CNT_W:0]     req_len;
  logic [REG_AW-1:0]  start_idx;
  logic [REG_AW-1:0]  next_idx;
  logic               accept;
  logic               unused_instr_bits;

  assign unused_instr_bits = ^instr[INSTR_W-1:FIELD_W];

  reg_index_gen #(
    .FIELD_W    (FIELD_W),
    .REG_AW     (REG_AW),
    .FRAME_BASE (FRAME_BASE)
  ) u_index_gen (
    .mode      (mode),
    .field     (instr[FIELD_W-1:0]),
    .cur_field (reg2[FIELD_W-1:0]),
    .start_idx (start_idx),
    .next_idx  (next_idx)
  );

  // Handshake: an element transfers in any cycle with reg2_valid high and
  // stall low; while stalled, reg2/offset hold and reg2_valid stays high.
  assign reg2_valid = (state == S_ISSUE);
  assign busy       = (state == S_ISSUE);
  assign accept     = (state == S_ISSUE) && !stall;
  assign done       = accept && (remaining == (CNT_W+1)'(1));

  always_comb begin
    req_len = (CNT_W+1)'(1);
    if (mode == MODE_BURST)
      req_len = (burst_len == '0) ? (CNT_W+1)'(MAX_BURST) : {1'b0, burst_len};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      reg2      <= '0;
      offset    <= '0;
      remaining <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_ISSUE;
            reg2      <= start_idx;
            offset    <= '0;
            remaining <= req_len;
          end
        end
        S_ISSUE: begin
          if (accept) begin
            if (remaining > (CNT_W+1)'(1)) begin
              reg2      <= next_idx;
              offset    <= offset + CNT_W'(1);
              remaining <= remaining - (CNT_W+1)'(1);
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_operand_sequencer.sv
// Self-checking bench for reg_operand_sequencer: directed steps plus a
// scoreboard of expected {reg2, offset, done} per accepted element.
module tb_reg_operand_sequencer;
  import tinyarch_pkg::*;

  localparam int W = 8;  // {reg2[3:0], offset[2:0], done}

  logic        clk;
  logic        reset;
  logic        start;
  logic [8:0]  instr;
  mode_t       mode;
  logic [2:0]  burst_len;
  logic        stall;
  logic [3:0]  reg2;
  logic        reg2_valid;
  logic [2:0]  offset;
  logic        busy;
  logic        done;

  logic [W-1:0] exp_q[$];
  int checks;
  int failures;

  reg_operand_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .instr      (instr),
    .mode       (mode),
    .burst_len  (burst_len),
    .stall      (stall),
    .reg2       (reg2),
    .reg2_valid (reg2_valid),
    .offset     (offset),
    .busy       (busy),
    .done       (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected sequence built independently from the instruction semantics.
  task automatic push_expected(input mode_t m, input logic [2:0] field, input logic [2:0] len);
    int n;
    logic [3:0] r;
    logic [2:0] f;
    n = (m == MODE_BURST) ? ((len == 3'd0) ? 8 : int'(len)) : 1;
    for (int i = 0; i < n; i++) begin
      f = field + 3'(i);
      r = (m == MODE_FRAME) ? 4'hd : {1'b0, f};
      exp_q.push_back({r, 3'(i), (i == n - 1)});
    end
  endtask

  // Drives one request for a single cycle; first element is valid on return.
  task automatic issue(input mode_t m, input logic [8:0] ins, input logic [2:0] len);
    start     = 1'b1;
    mode      = m;
    instr     = ins;
    burst_len = len;
    push_expected(m, ins[2:0], len);
    cyc();
    start = 1'b0;
    check("first_valid", reg2_valid, 1'b1);
  endtask

  // Counts further busy cycles until idle, bounded.
  task automatic wait_idle(output int busy_cycles);
    busy_cycles = 1;
    for (int i = 0; i < 60; i++) begin
      if (!busy) break;
      cyc();
      if (busy) busy_cycles++;
    end
    check("idle_timeout", busy, 1'b0);
  endtask

  // scoreboard monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (!reset) begin
      if (reg2_valid && !stall) begin
        if (exp_q.size() == 0) begin
          check("sb_depth", exp_q.size(), 1);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("element", {reg2, offset, done}, e);
        end
      end else begin
        check("done_quiet", done, 1'b0);
      end
    end
  end

  initial begin
    int bc;
    checks = 0; failures = 0;
    reset = 1'b1; start = 1'b0; instr = '0; mode = MODE_NORMAL;
    burst_len = '0; stall = 1'b0;
    cyc(); cyc();
    check("rst_reg2", reg2, 4'h0);
    check("rst_offset", offset, 3'd0);
    check("rst_valid_busy_done", {reg2_valid, busy, done}, 3'b000);
    reset = 1'b0;
    cyc(); cyc(); cyc();
    check("no_start_valid", reg2_valid, 1'b0);

    // NORMAL: single element, busy low two cycles after start
    issue(MODE_NORMAL, 9'h105, 3'd0);
    check("normal_reg2", reg2, 4'h5);
    check("normal_done", done, 1'b1);
    cyc();
    check("normal_busy_off", busy, 1'b0);
    cyc();

    // FRAME: instr ignored, frame base issued once
    issue(MODE_FRAME, 9'h003, 3'd0);
    check("frame_reg2", reg2, 4'hd);
    wait_idle(bc);
    check("frame_len", bc, 1);
    cyc();

    // reserved mode behaves as NORMAL
    issue(MODE_RSVD, 9'h0f6, 3'd5);
    wait_idle(bc);
    check("rsvd_len", bc, 1);
    cyc();

    // BURST field 6, length 4: wraps 7 -> 0
    issue(MODE_BURST, 9'h006, 3'd4);
    wait_idle(bc);
    check("burst4_len", bc, 4);
    check("burst4_drained", exp_q.size(), 0);
    cyc();

    // BURST length 0 encodes 8
    issue(MODE_BURST, 9'h0b3, 3'd0);
    wait_idle(bc);
    check("burst8_len", bc, 8);
    check("burst8_drained", exp_q.size(), 0);
    // back-to-back: start in the first idle cycle
    issue(MODE_NORMAL, 9'h001, 3'd0);
    check("b2b_reg2", reg2, 4'h1);
    cyc();

    // BURST field 2, length 3, stalled twice on second element; FRAME start ignored
    issue(MODE_BURST, 9'h002, 3'd3);
    cyc();
    stall = 1'b1; start = 1'b1; mode = MODE_FRAME; instr = 9'h007;
    check("stall_reg2_a", reg2, 4'h3);
    cyc();
    start = 1'b0;
    check("stall_reg2_b", {reg2, offset}, {4'h3, 3'd1});
    check("stall_valid", reg2_valid, 1'b1);
    cyc();
    stall = 1'b0;
    check("stall_reg2_c", {reg2, offset}, {4'h3, 3'd1});
    cyc();
    check("stall_last", {reg2, offset, done}, {4'h4, 3'd2, 1'b1});
    cyc();
    check("stall_busy_off", busy, 1'b0);
    check("stall_drained", exp_q.size(), 0);

    // BURST length 5 abandoned by reset at the third element
    issue(MODE_BURST, 9'h001, 3'd5);
    cyc();
    cyc();
    reset = 1'b1;
    #1;
    check("mid_rst_outs", {reg2, offset, reg2_valid, busy, done}, 10'd0);
    check("mid_rst_popped", exp_q.size(), 3);
    exp_q.delete();
    cyc();
    reset = 1'b0;
    cyc(); cyc();
    check("post_rst_valid", reg2_valid, 1'b0);
    issue(MODE_NORMAL, 9'h1f2, 3'd0);
    check("post_rst_reg2", reg2, 4'h2);
    cyc();

    // random bursts with random stalls
    for (int k = 0; k < 4; k++) begin
      logic [2:0] f, l;
      f = 3'($urandom_range(0, 7));
      l = 3'($urandom_range(0, 7));
      issue(MODE_BURST, {6'h0, f}, l);
      for (int i = 0; i < 100; i++) begin
        stall = 1'($urandom_range(0, 1));
        cyc();
        if (!busy) break;
      end
      stall = 1'b0;
      check("rand_idle", busy, 1'b0);
      check("rand_drained", exp_q.size(), 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_operand_sequencer.md
# reg_operand_sequencer

Second-operand register sequencer for the tinyarch core. It generalises the register-2 select path into a parametrised, registered block. The block issues the instruction-encoded register, the forced frame-base register for `sti`, or a multi-cycle burst of consecutive registers for block load/store. It sits between decode and the register-file read port, with a valid/stall handshake toward the execute stage.

## Interface
Parameters:
- `INSTR_W`, 9: instruction width.
- `FIELD_W`, 3: width of the reg2 field, which occupies `instr[FIELD_W-1:0]`.
- `REG_AW`, 4: register-file address width. Must be greater than `FIELD_W`.
- `FRAME_BASE`, 4'hd: register forced in frame-base mode.
- `MAX_BURST`, 8: maximum burst length. Must be a power of two and at least 2.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only while `busy` is low.
- `instr`  in  INSTR_W  instruction; sampled with `start`.
- `mode`  in  2  `mode_t`: 00 NORMAL, 01 FRAME, 10 BURST, 11 reserved (treated as NORMAL).
- `burst_len`  in  $clog2(MAX_BURST)  element count; 0 encodes MAX_BURST. Used in BURST mode only.
- `stall`  in  1  consumer stall; holds the current element.
- `reg2`  out  REG_AW  register address being issued.
- `reg2_valid`  out  1  `reg2` is meaningful this cycle.
- `offset`  out  $clog2(MAX_BURST)  element index within the burst; 0 for single issues.
- `busy`  out  1  high while in ISSUE.
- `done`  out  1  high in the cycle the final element is accepted.

## Operation
- States: IDLE and ISSUE. Internal registers: `state`, `reg2`, `offset`, `remaining` (width $clog2(MAX_BURST)+1).
- IDLE with `start`:
  - The block moves to ISSUE.
  - NORMAL / reserved: `reg2 <= zero-extend(instr[FIELD_W-1:0])`, `remaining <= 1`.
  - FRAME: `reg2 <= FRAME_BASE`, `remaining <= 1`. `instr` is ignored.
  - BURST: `reg2 <= zero-extend(field)`, `remaining <= (burst_len==0 ? MAX_BURST : burst_len)`.
  - `offset <= 0` in all modes.
- ISSUE:
  - `reg2_valid = 1`, `busy = 1`.
  - Element accepted = `!stall`.
  - On accept with `remaining > 1`: the field part of `reg2` increments modulo 2^FIELD_W, with the upper bits staying 0. `offset` increments and `remaining` decrements.
  - On accept with `remaining == 1`: `done = 1` this cycle, and the block returns to IDLE at the next edge.
- `done = (state==ISSUE) && !stall && (remaining==1)`. It is decoded from registers, and the block has no combinational path from `instr` or `mode`.
- `start` while `busy` is ignored and the sequence continues unaffected.
- With `stall` held high, `reg2` and `offset` are frozen and `reg2_valid` stays high indefinitely.
- Reset (asynchronous, at any time, including mid-burst):
  - State goes to IDLE.
  - `reg2 = 0`, `offset = 0`, `remaining = 0`.
  - `reg2_valid`, `busy` and `done` go to 0.
  - The partial burst is abandoned and no `done` is generated.

## Timing
- Latency: `start` in cycle N puts the first element valid in cycle N+1.
- Unstalled burst of L elements: valid in cycles N+1 to N+L; `done` in cycle N+L; `busy` low in N+L+1.
- The earliest next `start` is sampled in cycle N+L+1, giving one idle cycle between back-to-back requests.
- Each stall cycle extends the sequence by exactly one cycle.
- All outputs except `done` are registered.

## Structure
- Shared package `tinyarch_pkg` holds:
  - `typedef enum logic [1:0] mode_t {MODE_NORMAL, MODE_FRAME, MODE_BURST, MODE_RSVD}`.
  - `typedef enum logic state_t {S_IDLE, S_ISSUE}`.
  - `localparam FRAME_BASE_REG = 4'hd`, used as the default for `FRAME_BASE`.
- Sub-module `reg_index_gen` (combinational) computes the start index and the wrapped next index from mode, field and current `reg2`. The FSM and counters stay in the top module.

## Test plan
- Reset with `reset` high mid-operation -> all outputs 0 immediately; after release with no `start`, `reg2_valid` stays 0.
- NORMAL with `instr=9'h105`, `start` in cycle N -> `reg2=4'h5`, `reg2_valid=1`, `done=1` in N+1; `busy=0` in N+2.
- FRAME with `instr=9'h003` -> `reg2=4'hd` in N+1 and a single `done`.
- BURST with field 6 and `burst_len=4` -> `reg2` = 6, 7, 0, 1 with `offset` = 0, 1, 2, 3; `done` only with the final element; `burst_len=0` -> 8 elements.
- BURST with field 2, `burst_len=3`, `stall` high for 2 cycles at the second element -> `reg2=3` is held for 3 cycles and `done` is in N+5. A `start` with `mode=01` pulsed during the burst is ignored.
- BURST with `burst_len=5` and `reset` asserted at the third element -> outputs 0 at once and no `done`. A new NORMAL `start` after release -> valid 1 cycle later.
